host_dword_framer: RTL and testbench



---
 rtl/host_dword_framer_pkg.sv | 26 ++
 rtl/host_dword_framer_byte_packer.sv | 50 +++++
 rtl/host_dword_framer.sv | 178 +++++++++++++++++
 tb/tb_host_dword_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_dword_framer_pkg.sv
// Shared types for the host byte-stream to dword framer: header layout,
// pad word and framer state encoding.
package host_dword_framer_pkg;

    localparam int          HDR_CMD  = 0;
    localparam int          HDR_LEN  = 8;
    localparam int          HDR_QUAD = 16;
    localparam logic [31:0] PAD_WORD = 32'hFFFF_FFFF;

    // Field order mirrors HDR_CMD/HDR_LEN/HDR_QUAD; reserved bits ride along untouched.
    typedef struct packed {
        logic [14:0] reserved;
        logic        quad;
        logic [7:0]  len;
        logic [7:0]  cmd;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_HDR      = 3'd0,
        ST_HDR_WAIT = 3'd1,
        ST_DATA     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_PAD      = 3'd4
    } state_t;

endpackage

// File: rtl/host_dword_framer_byte_packer.sv
// Little-endian byte-to-dword assembly with a single output slot and the
// host-side ready logic.
module byte_packer (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        hold_off,
    input  logic        release_slot,
    input  logic        flush,
    output logic        rx_ready,
    output logic        accept,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  byte_cnt
);

    logic [23:0] asm_q;

    // The 4th byte can only land if the slot is free, which costs at most one bubble.
    assign rx_ready = !reset && !(byte_cnt == 2'd3 && out_valid) && !hold_off;
    assign accept   = rx_valid && rx_ready;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            asm_q     <= 24'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
        end else begin
            if (release_slot)
                out_valid <= 1'b0;
            if (flush) begin
                byte_cnt <= 2'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: asm_q[7:0]   <= rx_data;
                    2'd1: asm_q[15:8]  <= rx_data;
                    2'd2: asm_q[23:16] <= rx_data;
                    default: begin
                        out_data  <= {rx_data, asm_q};
                        out_valid <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/host_dword_framer.sv
// Turns the host byte stream into header/data dword strobes for dword_interface,
// gating headers on busy and padding frames cut short by an inter-byte timeout.
module host_dword_framer
    import host_dword_framer_pkg::*;
#(
    parameter int MAX_LEN = 65,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        busy,
    output logic        wr,
    output logic [31:0] data_from_PC,
    output logic        frame_err
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        dw_left;
    logic [7:0]        skip_left;
    logic [IDLE_W-1:0] idle_cnt;

    logic              accept;
    logic              slot_valid;
    logic [31:0]       slot_data;
    logic [1:0]        byte_cnt;
    logic              release_slot;
    logic              hold_off;
    logic              idle_active;
    logic              timeout;
    logic              oversize;
    hdr_t              hdr;

    assign hdr      = hdr_t'(slot_data);
    assign oversize = int'(hdr.len) > MAX_LEN;
    assign hold_off = (state == ST_PAD);

    // A byte accepted in the expiry cycle counts as activity, so it suppresses the timeout.
    assign idle_active = (byte_cnt != 2'd0) || (state == ST_DATA) || (state == ST_DRAIN);
    assign timeout     = idle_active && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    byte_packer u_packer (
        .clk_in       (clk_in),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .hold_off     (hold_off),
        .release_slot (release_slot),
        .flush        (timeout),
        .rx_ready     (rx_ready),
        .accept       (accept),
        .out_valid    (slot_valid),
        .out_data     (slot_data),
        .byte_cnt     (byte_cnt)
    );

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            state <= ST_HDR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (slot_valid)
                    state_nxt = oversize ? ST_DRAIN : ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                if (slot_valid && !busy)
                    state_nxt = (hdr.len == 8'd0) ? ST_HDR : ST_DATA;
            end
            ST_DATA: begin
                if (timeout)
                    state_nxt = ST_PAD;
                else if (slot_valid && dw_left <= 8'd1)
                    state_nxt = ST_HDR;
            end
            ST_DRAIN: begin
                if (timeout)
                    state_nxt = ST_HDR;
                else if (slot_valid && skip_left <= 8'd1)
                    state_nxt = ST_HDR;
            end
            ST_PAD: begin
                if (dw_left <= 8'd1)
                    state_nxt = ST_HDR;
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    // Data words go out the cycle after assembly whatever busy says; only headers wait.
    always_comb begin
        wr           = 1'b0;
        data_from_PC = slot_data;
        frame_err    = 1'b0;
        release_slot = 1'b0;
        case (state)
            ST_HDR: begin
                if (slot_valid && oversize) begin
                    frame_err    = 1'b1;
                    release_slot = 1'b1;
                end
            end
            ST_HDR_WAIT: begin
                if (slot_valid && !busy) begin
                    wr           = 1'b1;
                    release_slot = 1'b1;
                end
            end
            ST_DATA: begin
                if (slot_valid) begin
                    wr           = 1'b1;
                    release_slot = 1'b1;
                end
                if (timeout)
                    frame_err = 1'b1;
            end
            ST_DRAIN: begin
                if (slot_valid)
                    release_slot = 1'b1;
            end
            ST_PAD: begin
                wr           = 1'b1;
                data_from_PC = PAD_WORD;
            end
            default: begin
                wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            idle_cnt  <= '0;
            dw_left   <= 8'd0;
            skip_left <= 8'd0;
        end else begin
            if (accept || !idle_active || timeout)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + IDLE_W'(1);

            case (state)
                ST_HDR_WAIT: begin
                    if (slot_valid && !busy)
                        dw_left <= hdr.len;
                end
                ST_DATA: begin
                    if (slot_valid && !timeout)
                        dw_left <= dw_left - 8'd1;
                end
                ST_PAD: begin
                    dw_left <= dw_left - 8'd1;
                end
                default: begin
                    dw_left <= dw_left;
                end
            endcase

            if (state == ST_HDR && slot_valid && oversize)
                skip_left <= hdr.len;
            else if (state == ST_DRAIN && timeout)
                skip_left <= 8'd0;
            else if (state == ST_DRAIN && slot_valid)
                skip_left <= skip_left - 8'd1;
        end
    end

endmodule

// File: tb/tb_host_dword_framer.sv
// Directed bench for host_dword_framer: every wr strobe is logged by a monitor
// and each scenario task compares the log against hand-computed words.
module tb_host_dword_framer;

    localparam int TB_TIMEOUT = 40;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        busy = 1'b0;
    logic        rx_ready;
    logic        wr;
    logic [31:0] data_from_PC;
    logic        frame_err;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_pulses = 0;
    logic [31:0] wr_q[$];
    int          wr_cyc[$];
    logic        wr_busy[$];

    host_dword_framer #(.MAX_LEN(65), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .busy         (busy),
        .wr           (wr),
        .data_from_PC (data_from_PC),
        .frame_err    (frame_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // Inputs change on the falling edge; outputs are logged a little later in the low phase.
    always @(negedge clk_in) begin
        #2;
        if (wr === 1'b1) begin
            wr_q.push_back(data_from_PC);
            wr_cyc.push_back(cyc);
            wr_busy.push_back(busy);
        end
        if (frame_err === 1'b1)
            err_pulses++;
    end

    function automatic logic [31:0] word_at(int idx);
        if (idx < wr_q.size())
            return wr_q[idx];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int cyc_at(int idx);
        if (idx < wr_cyc.size())
            return wr_cyc[idx];
        return -1000;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int guard;
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 500) begin
            acc = rx_ready;
            @(negedge clk_in);
            guard++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL send_byte: byte %02h not accepted, rx_ready low for %0d cycles", b, guard);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_in);
        n_checks++;
        if (wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr: got %b expected 0", wr); end
        n_checks++;
        if (data_from_PC !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 00000000", data_from_PC); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++;
        if (rx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (rx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_rx_ready: got %b expected 1", rx_ready); end
        @(negedge clk_in);
    endtask

    task automatic test_single_header;
        int base;
        int e0;
        base = wr_q.size();
        e0   = err_pulses;
        busy = 1'b0;
        send_word(32'h0000_0006);
        idle(6);
        n_checks++;
        if (wr_q.size() - base !== 1) begin n_fail++; $display("[TB] FAIL single_hdr_count: got %0d expected 1", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_0006) begin n_fail++; $display("[TB] FAIL single_hdr_word: got %h expected 00000006", word_at(base)); end
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("[TB] FAIL single_hdr_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_busy_hold;
        int base;
        int fall_cyc;
        base     = wr_q.size();
        fall_cyc = 0;
        busy     = 1'b1;
        fork
            begin
                int g;
                repeat (20) @(negedge clk_in);
                busy     = 1'b0;
                fall_cyc = cyc;
                g        = 0;
                while (wr_q.size() == base && g < 100) begin
                    @(negedge clk_in);
                    g++;
                end
                busy = 1'b1;
            end
            begin
                send_word(32'h0000_0202);
                send_word(32'h4433_2211);
                send_word(32'h8877_6655);
                rx_valid = 1'b0;
            end
        join
        idle(8);
        busy = 1'b0;
        n_checks++;
        if (wr_q.size() - base !== 3) begin n_fail++; $display("[TB] FAIL busy_count: got %0d expected 3", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_0202) begin n_fail++; $display("[TB] FAIL busy_hdr_word: got %h expected 00000202", word_at(base)); end
        n_checks++;
        if (word_at(base + 1) !== 32'h4433_2211) begin n_fail++; $display("[TB] FAIL busy_data0: got %h expected 44332211", word_at(base + 1)); end
        n_checks++;
        if (word_at(base + 2) !== 32'h8877_6655) begin n_fail++; $display("[TB] FAIL busy_data1: got %h expected 88776655", word_at(base + 2)); end
        n_checks++;
        if (cyc_at(base) < fall_cyc || cyc_at(base) > fall_cyc + 2) begin
            n_fail++;
            $display("[TB] FAIL busy_hdr_timing: header wr at cycle %0d, busy fell at cycle %0d (required within 0..2 after)", cyc_at(base), fall_cyc);
        end
        if (wr_busy.size() >= base + 3) begin
            n_checks++;
            if (wr_busy[base] !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_hdr_gate: busy at header wr %b expected 0", wr_busy[base]); end
            n_checks++;
            if (wr_busy[base + 1] !== 1'b1 || wr_busy[base + 2] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL busy_data_ignore: busy at data wr %b%b expected 11", wr_busy[base + 1], wr_busy[base + 2]);
            end
        end
    endtask

    task automatic test_oversize;
        int base;
        int e0;
        base = wr_q.size();
        e0   = err_pulses;
        send_word(32'h0000_4602);
        for (int i = 0; i < 280; i++)
            send_byte(8'(i));
        idle(4);
        n_checks++;
        if (wr_q.size() - base !== 0) begin n_fail++; $display("[TB] FAIL oversize_no_wr: got %0d wr expected 0", wr_q.size() - base); end
        n_checks++;
        if (err_pulses - e0 !== 1) begin n_fail++; $display("[TB] FAIL oversize_err: got %0d pulses expected 1", err_pulses - e0); end
        send_word(32'h0000_0006);
        idle(6);
        n_checks++;
        if (wr_q.size() - base !== 1) begin n_fail++; $display("[TB] FAIL oversize_next_count: got %0d expected 1", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_0006) begin n_fail++; $display("[TB] FAIL oversize_next_word: got %h expected 00000006", word_at(base)); end
    endtask

    task automatic test_pad_timeout;
        int base;
        int e0;
        base = wr_q.size();
        e0   = err_pulses;
        send_word(32'h0000_0302);
        send_word(32'h0403_0201);
        idle(TB_TIMEOUT + 10);
        n_checks++;
        if (wr_q.size() - base !== 4) begin n_fail++; $display("[TB] FAIL pad_count: got %0d expected 4", wr_q.size() - base); end
        n_checks++;
        if (word_at(base + 1) !== 32'h0403_0201) begin n_fail++; $display("[TB] FAIL pad_data0: got %h expected 04030201", word_at(base + 1)); end
        n_checks++;
        if (word_at(base + 2) !== 32'hFFFF_FFFF || word_at(base + 3) !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL pad_words: got %h %h expected ffffffff ffffffff", word_at(base + 2), word_at(base + 3));
        end
        n_checks++;
        if (err_pulses - e0 !== 1) begin n_fail++; $display("[TB] FAIL pad_err: got %0d pulses expected 1", err_pulses - e0); end
        n_checks++;
        if (rx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL pad_exit_ready: got %b expected 1", rx_ready); end
    endtask

    task automatic test_partial_header_timeout;
        int base;
        int e0;
        base = wr_q.size();
        e0   = err_pulses;
        send_byte(8'hAA);
        send_byte(8'hBB);
        idle(TB_TIMEOUT + 5);
        send_word(32'h0000_0006);
        idle(6);
        n_checks++;
        if (wr_q.size() - base !== 1) begin n_fail++; $display("[TB] FAIL partial_hdr_count: got %0d expected 1", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_0006) begin n_fail++; $display("[TB] FAIL partial_hdr_word: got %h expected 00000006", word_at(base)); end
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("[TB] FAIL partial_hdr_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_timeout_boundary;
        int base;
        int e0;
        base = wr_q.size();
        e0   = err_pulses;
        send_word(32'h0000_0202);
        send_byte(8'h01);
        send_byte(8'h02);
        rx_valid = 1'b0;
        repeat (TB_TIMEOUT - 1) @(negedge clk_in);
        send_byte(8'h03);
        send_byte(8'h04);
        send_word(32'h0807_0605);
        idle(6);
        n_checks++;
        if (wr_q.size() - base !== 3) begin n_fail++; $display("[TB] FAIL boundary_count: got %0d expected 3", wr_q.size() - base); end
        n_checks++;
        if (word_at(base + 1) !== 32'h0403_0201) begin n_fail++; $display("[TB] FAIL boundary_data0: got %h expected 04030201", word_at(base + 1)); end
        n_checks++;
        if (word_at(base + 2) !== 32'h0807_0605) begin n_fail++; $display("[TB] FAIL boundary_data1: got %h expected 08070605", word_at(base + 2)); end
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("[TB] FAIL boundary_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_back_to_back;
        int          base;
        int          e0;
        logic [31:0] exp;
        int          gap;
        base = wr_q.size();
        e0   = err_pulses;
        busy = 1'b0;
        send_word(32'h0000_4102);
        for (int i = 0; i < 260; i++)
            send_byte(8'(i));
        idle(8);
        n_checks++;
        if (wr_q.size() - base !== 66) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 66", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_4102) begin n_fail++; $display("[TB] FAIL b2b_hdr: got %h expected 00004102", word_at(base)); end
        n_checks++;
        if (cyc_at(base + 1) <= cyc_at(base)) begin
            n_fail++;
            $display("[TB] FAIL b2b_first_data: data wr cycle %0d, header wr cycle %0d (required later)", cyc_at(base + 1), cyc_at(base));
        end
        for (int j = 0; j < 65; j++) begin
            exp = {8'(4*j + 3), 8'(4*j + 2), 8'(4*j + 1), 8'(4*j)};
            n_checks++;
            if (word_at(base + 1 + j) !== exp) begin
                n_fail++;
                $display("[TB] FAIL b2b_word%0d: got %h expected %h", j, word_at(base + 1 + j), exp);
            end
            if (j > 0) begin
                gap = cyc_at(base + 1 + j) - cyc_at(base + j);
                n_checks++;
                if (gap < 4 || gap > 5) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d cycles expected 4..5", j, gap);
                end
            end
        end
        n_checks++;
        if (err_pulses - e0 !== 0) begin n_fail++; $display("[TB] FAIL b2b_err: got %0d expected 0", err_pulses - e0); end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        base = wr_q.size();
        send_word(32'h0000_0202);
        send_byte(8'h11);
        send_byte(8'h22);
        rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (wr !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_wr: got %b expected 0", wr); end
        n_checks++;
        if (data_from_PC !== 32'd0) begin n_fail++; $display("[TB] FAIL midreset_data: got %h expected 00000000", data_from_PC); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_frame_err: got %b expected 0", frame_err); end
        n_checks++;
        if (rx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rx_ready: got %b expected 0", rx_ready); end
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        @(negedge clk_in);
        send_word(32'h0000_0006);
        idle(6);
        n_checks++;
        if (wr_q.size() - base !== 2) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d expected 2", wr_q.size() - base); end
        n_checks++;
        if (word_at(base) !== 32'h0000_0202) begin n_fail++; $display("[TB] FAIL midreset_first_hdr: got %h expected 00000202", word_at(base)); end
        n_checks++;
        if (word_at(base + 1) !== 32'h0000_0006) begin n_fail++; $display("[TB] FAIL midreset_fresh_hdr: got %h expected 00000006", word_at(base + 1)); end
    endtask

    initial begin
        test_reset();
        test_single_header();
        test_busy_hold();
        test_oversize();
        test_pad_timeout();
        test_partial_header_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
